// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round-constant seed, GF(2^8) doubling,
// legal key lengths, round-count helper and the sequencer state encoding.
// KEY_EXPAND_ZEROIZE_EN adds the ZERO state to the encoding.
package aes_pkg;

  localparam logic [7:0] RCON_INIT    = 8'h01;
  localparam int         KEY_BITS_128 = 128;
  localparam int         KEY_BITS_192 = 192;
  localparam int         KEY_BITS_256 = 256;

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

`ifdef KEY_EXPAND_ZEROIZE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2,
    ST_ZERO   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/sbox_4byte.sv
// Four parallel AES forward S-boxes; one column, used for SubWord.
module sbox_4byte (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte-wise table lookup.
  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/key_expand_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into a
// word store, round keys served by index through a registered read port.
// Optional KEY_EXPAND_ZEROIZE_EN adds i_zeroize and a word-by-word clear.
//
// state  | meaning
// IDLE   | no schedule held (after reset or zeroize)
// EXPAND | writing w[i], one word per cycle, i = NK..NW-1
// DONE   | store holds a complete schedule, round keys readable
// ZERO   | clearing w[0..NW-1] one word per cycle (zeroize build only)
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = KEY_BITS_128
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef KEY_EXPAND_ZEROIZE_EN
  input  logic                i_zeroize,
`endif
  input  logic                i_start,
  input  logic [KEY_BITS-1:0] i_key_in,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rk_valid,
  input  logic [3:0]          i_rk_idx,
  output logic [127:0]        o_rk_out
);

  if (KEY_BITS != KEY_BITS_128 && KEY_BITS != KEY_BITS_192 &&
      KEY_BITS != KEY_BITS_256) begin : g_bad_key_bits
    $error("key_expand_seq: KEY_BITS must be 128, 192 or 256");
  end

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W      = 6'(NK);
  localparam logic [5:0] LAST_W    = 6'(NW - 1);
  localparam logic [2:0] KMOD_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W      = 4'(NR);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_w [NW];
  logic [5:0]    r_i;
  logic [2:0]    r_kmod;
  logic [7:0]    r_rcon;
  logic          r_done;
  logic [127:0]  r_rk_out;

  logic          w_load;
  logic          w_expand_wr;
  logic          w_zero_wr;
  logic          w_zero_start;
  logic          w_last;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [5:0]    w_base;

  // Schedule word recurrence; the single S-box column is shared by RotWord
  // steps (kmod==0) and the extra AES-256 SubWord step (kmod==4).
  assign w_prev   = r_w[r_i - 6'd1];
  assign w_back   = r_w[r_i - NK_W];
  assign w_sub_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  sbox_4byte u_sbox (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Select temp for the current word.
  always_comb begin
    w_temp = w_prev;
    if (r_kmod == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if (NK == 8 && r_kmod == 3'd4) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  // Next-state, datapath strobes and status outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_expand_wr  = 1'b0;
    w_zero_wr    = 1'b0;
    w_zero_start = 1'b0;
    w_last       = 1'b0;
    o_busy       = 1'b0;
    o_rk_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_EXPAND;
          w_load      = 1'b1;
        end
      end
      ST_EXPAND: begin
        o_busy      = 1'b1;
        w_expand_wr = 1'b1;
        if (r_i == LAST_W) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE: begin
        o_rk_valid = 1'b1;
        if (i_start) begin
          w_state_nxt = ST_EXPAND;
          w_load      = 1'b1;
        end
      end
`ifdef KEY_EXPAND_ZEROIZE_EN
      ST_ZERO: begin
        o_busy    = 1'b1;
        w_zero_wr = 1'b1;
        if (r_i == LAST_W) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
`ifdef KEY_EXPAND_ZEROIZE_EN
    // Zeroize pre-empts everything, including a clear already in progress.
    if (i_zeroize) begin
      w_state_nxt  = ST_ZERO;
      w_zero_start = 1'b1;
      w_load       = 1'b0;
      w_expand_wr  = 1'b0;
      w_zero_wr    = 1'b0;
      w_last       = 1'b0;
    end
`endif
  end

  // State register, word index, kmod and rcon sequencing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_i     <= 6'd0;
      r_kmod  <= 3'd0;
      r_rcon  <= RCON_INIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_zero_start) begin
        r_i <= 6'd0;
      end else if (w_load) begin
        r_i    <= NK_W;
        r_kmod <= 3'd0;
        r_rcon <= RCON_INIT;
      end else if (w_expand_wr) begin
        r_i    <= r_i + 6'd1;
        r_kmod <= (r_kmod == KMOD_LAST) ? 3'd0 : r_kmod + 3'd1;
        if (r_kmod == 3'd0) begin
          r_rcon <= xtime(r_rcon);
        end
      end else if (w_zero_wr) begin
        r_i <= r_i + 6'd1;
      end
    end
  end

  // Word store; deliberately not cleared by reset, only by load/expand/zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_load) begin
        for (int k = 0; k < NK; k++) begin
          r_w[k] <= i_key_in[KEY_BITS-1-32*k -: 32];
        end
      end else if (w_expand_wr) begin
        r_w[r_i] <= w_new;
      end else if (w_zero_wr) begin
        r_w[r_i] <= 32'h0;
      end
    end
  end

  assign w_base = {i_rk_idx, 2'b00};

  // Registered round-key read; zero unless a complete schedule is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rk_out <= '0;
    end else if (o_rk_valid && i_rk_idx <= NR_W) begin
      r_rk_out <= {r_w[w_base], r_w[w_base + 6'd1],
                   r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
    end else begin
      r_rk_out <= '0;
    end
  end

  assign o_done   = r_done;
  assign o_rk_out = r_rk_out;

endmodule

// File: tb/tb_key_expand_seq.sv
// Scoreboard bench for key_expand_seq: one instance per key length, known
// FIPS-197 vectors. KEY_EXPAND_ZEROIZE_EN enables the zeroize section.
module tb_key_expand_seq;
  import aes_pkg::*;

  localparam logic [255:0] K128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [2:0]          start_v;
  logic [2:0][255:0]   key_v;
  logic [2:0][3:0]     idx_v;
  logic [2:0]          busy_v, done_v, valid_v;
  logic [2:0][127:0]   rk_v;
`ifdef KEY_EXPAND_ZEROIZE_EN
  logic                zeroize;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [127:0]  exp_q [$];
  string         tag_q [$];

  key_expand_seq #(.KEY_BITS(128)) dut128 (
    .i_clk(clk), .i_rst(rst),
`ifdef KEY_EXPAND_ZEROIZE_EN
    .i_zeroize(zeroize),
`endif
    .i_start(start_v[0]), .i_key_in(key_v[0][127:0]),
    .o_busy(busy_v[0]), .o_done(done_v[0]), .o_rk_valid(valid_v[0]),
    .i_rk_idx(idx_v[0]), .o_rk_out(rk_v[0]));

  key_expand_seq #(.KEY_BITS(192)) dut192 (
    .i_clk(clk), .i_rst(rst),
`ifdef KEY_EXPAND_ZEROIZE_EN
    .i_zeroize(1'b0),
`endif
    .i_start(start_v[1]), .i_key_in(key_v[1][191:0]),
    .o_busy(busy_v[1]), .o_done(done_v[1]), .o_rk_valid(valid_v[1]),
    .i_rk_idx(idx_v[1]), .o_rk_out(rk_v[1]));

  key_expand_seq #(.KEY_BITS(256)) dut256 (
    .i_clk(clk), .i_rst(rst),
`ifdef KEY_EXPAND_ZEROIZE_EN
    .i_zeroize(1'b0),
`endif
    .i_start(start_v[2]), .i_key_in(key_v[2]),
    .o_busy(busy_v[2]), .o_done(done_v[2]), .o_rk_valid(valid_v[2]),
    .i_rk_idx(idx_v[2]), .o_rk_out(rk_v[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [127:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [127:0] obs);
    if (exp_q.size() == 0) begin
      chk("sb_empty", obs, ~obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic rd(input int sel, input logic [3:0] idx, input logic [127:0] exp, input string tag);
    @(negedge clk);
    idx_v[sel] = idx;
    sb_push(tag, exp);
    @(posedge clk);
    #1;
    sb_pop(rk_v[sel]);
  endtask

  // Start pulse, then watch done latency and rk_valid low time; optionally
  // re-pulse start at cycle mid_start of the expansion (must be ignored).
  task automatic run_expand(input int sel, input logic [255:0] key, input int exp_cyc,
                            input int mid_start, input string tag);
    int n;
    int vlow;
    @(negedge clk);
    key_v[sel]   = key;
    start_v[sel] = 1'b1;
    sb_push({tag, "_latency"}, 128'(exp_cyc));
    sb_push({tag, "_valid_low"}, 128'(exp_cyc - 1));
    n    = 0;
    vlow = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start_v[sel] = 1'b0;
        chk({tag, "_busy_t1"}, 128'(busy_v[sel]), 128'(1));
      end
      if (n == mid_start) start_v[sel] = 1'b1;
      else if (n == mid_start + 1) start_v[sel] = 1'b0;
      if (!valid_v[sel]) vlow++;
      if (done_v[sel]) break;
    end
    sb_pop(128'(n));
    sb_pop(128'(vlow));
    chk({tag, "_busy_done"}, 128'(busy_v[sel]), 128'(0));
    chk({tag, "_valid_done"}, 128'(valid_v[sel]), 128'(1));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 128'(done_v[sel]), 128'(0));
  endtask

  initial begin
    rst     = 1'b1;
    start_v = '0;
    key_v   = '0;
    idx_v   = '0;
`ifdef KEY_EXPAND_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_busy", 128'(busy_v[s]), 128'(0));
      chk("rst_done", 128'(done_v[s]), 128'(0));
      chk("rst_valid", 128'(valid_v[s]), 128'(0));
      chk("rst_rk", rk_v[s], 128'h0);
    end
    rst = 1'b0;

    // AES-128 reference schedule
    run_expand(0, K128, 41, 0, "k128");
    rd(0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "k128_rk0");
    rd(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "k128_rk1");
    rd(0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "k128_rk2");
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128_rk10");
    rd(0, 4'd11, 128'h0, "k128_rk11_oor");
    rd(0, 4'd15, 128'h0, "k128_rk15_oor");

    // AES-192
    run_expand(1, K192, 47, 0, "k192");
    rd(1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "k192_rk0");
    rd(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "k192_rk12");
    rd(1, 4'd13, 128'h0, "k192_rk13_oor");

    // AES-256
    run_expand(2, K256, 53, 0, "k256");
    rd(2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "k256_rk0");
    rd(2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "k256_rk1");
    rd(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "k256_rk14");
    rd(2, 4'd15, 128'h0, "k256_rk15_oor");

    // start pulsed mid-expansion must not change timing or result
    run_expand(0, K128, 41, 10, "k128_midstart");
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "midstart_rk10");

    // rst mid-expansion
    @(negedge clk);
    key_v[0]   = K128;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(busy_v[0]), 128'(0));
    chk("midrst_valid", 128'(valid_v[0]), 128'(0));
    chk("midrst_rk", rk_v[0], 128'h0);
    chk("midrst_state", 128'(dut128.r_state), 128'(ST_IDLE));
    @(negedge clk);
    chk("midrst_done", 128'(done_v[0]), 128'(0));
    run_expand(0, K128, 41, 0, "k128_after_rst");
    rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "after_rst_rk1");

    // rst while DONE with a valid index clears the read register
    @(negedge clk);
    idx_v[0] = 4'd1;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("donerst_rk", rk_v[0], 128'h0);
    chk("donerst_valid", 128'(valid_v[0]), 128'(0));

    // all-zero key
    run_expand(0, 256'h0, 41, 0, "kzero");
    rd(0, 4'd1,  128'h62636363626363636263636362636363, "kzero_rk1");
    rd(0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "kzero_rk10");

`ifdef KEY_EXPAND_ZEROIZE_EN
    begin
      int cnt;
      int bad;
      run_expand(0, K128, 41, 0, "k128_pre_zero");
      @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      cnt = 0;
      bad = 0;
      while (busy_v[0] && cnt < 200) begin
        cnt++;
        if (valid_v[0] || done_v[0]) bad++;
        @(negedge clk);
      end
      chk("zero_busy_cycles", 128'(cnt), 128'(44));
      chk("zero_valid_done", 128'(bad), 128'(0));
      chk("zero_state", 128'(dut128.r_state), 128'(ST_IDLE));
      for (int k = 0; k < 44; k++) begin
        chk("zero_word", 128'(dut128.r_w[k]), 128'h0);
      end
      rd(0, 4'd0, 128'h0, "zero_rk0");
    end
`endif

    if (exp_q.size() != 0) chk("sb_leftover", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
Iterative, parametrised AES key-schedule engine supporting AES-128, AES-192 and AES-256. It generates one 32-bit schedule word per clock into an internal word store. Round keys are then served by index through a registered read port. It replaces the fully unrolled combinational schedule and feeds the round datapath or any cipher core that fetches round keys on demand.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128/192/256, anything else is an elaboration error.
NK, KEY_BITS/32, key length in words (derived localparam: 4/6/8).
NR, NK+6, number of rounds (derived localparam: 10/12/14).
NW, 4*(NR+1), schedule words stored (derived localparam: 44/52/60).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  single-cycle request to expand key_in; sampled only in IDLE or DONE.
key_in  in  KEY_BITS  cipher key; word 0 = key_in[KEY_BITS-1 -: 32] (FIPS-197 byte order, MSB first).
busy  out  1  high while a key is loaded or being expanded.
done  out  1  one-cycle pulse when expansion completes.
rk_valid  out  1  level; high while the store holds a complete schedule.
rk_idx  in  4  round-key index, 0..NR.
rk_out  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered.

Behaviour:
- Reset is synchronous and active-high. On rst: state=IDLE; busy=0, done=0, rk_valid=0, rk_out=0. The word store is not cleared. rst mid-expansion aborts immediately, and nothing partial is ever flagged valid.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE with start=1 (cycle T):
  - capture w[0..NK-1] from key_in.
  - set i=NK, kmod=0, rcon=8'h01.
  - next state EXPAND; rk_valid=0 and busy=1 from T+1.
- EXPAND: each cycle write w[i] = w[i-NK] ^ temp, where temp = w[i-1], and:
  - if kmod==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon advances by xtime (0x80 -> 0x1b).
  - else if NK==8 and kmod==4: temp = SubWord(w[i-1]).
  - kmod counts 0..NK-1 and wraps; no divider or modulo hardware.
- On the write of w[NW-1], next state is DONE:
  - done pulses for exactly that one cycle.
  - rk_valid=1 and busy=0 from the same cycle.
  - EXPAND occupies NW-NK cycles: 40/46/52. done is asserted NW-NK+1 cycles after the start cycle.
- DONE holds until the next start or rst. A new start restarts expansion: rk_valid drops the next cycle and the store is overwritten.
- start in EXPAND is ignored and has no queued effect.
- Read port:
  - rk_out <= rk_valid && rk_idx<=NR ? stored key : 128'h0. Latency is 1 cycle.
  - An out-of-range index, or any read while rk_valid=0, returns zero.
- Only one S-box column (4 byte LUTs) is instantiated, shared across cycles.

Optional Feature:
KEY_EXPAND_ZEROIZE_EN
- Defined: adds input port zeroize (1 bit). zeroize=1 in any state aborts the current operation and enters state ZERO.
  - ZERO clears one word per cycle, w[0]..w[NW-1], over NW cycles, with busy=1 and rk_valid=0.
  - Then ZERO returns to IDLE; no done pulse is generated.
  - start during ZERO is ignored. zeroize during ZERO restarts the clear from w[0]. rst overrides zeroize.
- Undefined: no zeroize port and no ZERO state; the key store is only overwritten by a new expansion.

Decomposition:
- Shared package aes_pkg: RCON_INIT constant (8'h01); xtime function; legal KEY_BITS constants; nr_of(key_bits) function; state encoding typedef.
- One natural sub-module: the existing sbox_4byte (4 parallel byte S-boxes), reused for SubWord.
- RotWord and XOR logic stay inline.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done 41 cycles after the start cycle. rk_idx=1 -> a0fafe1788542cb123a339392a6c7605. rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles. rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles. rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- start pulsed mid-EXPAND, then rst asserted mid-EXPAND -> the start is ignored (done timing unchanged). After rst: rk_valid=0, rk_out=0, state IDLE, and the next start produces the correct schedule.
- After done, rk_idx=11 with KEY_BITS=128 -> rk_out=0. A second start with the all-zero key -> rk_valid low for 40 cycles, then rk_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- KEY_EXPAND_ZEROIZE_EN: zeroize after done -> busy for NW cycles, rk_valid=0, no done pulse, and every stored word reads 0 afterwards (checked by hierarchical peek).
